wtmdl_mc: RTL
=============

Name: wtmdl_mc

Overview:
Multi-channel successor of the single wait module, used by the wishbone slave sequencers.
- Provides NumChannels independent wait timers.
- Each channel supports a programmable prescaler, one-shot or periodic mode, abort, and a busy flag.
- Each channel emits a one-cycle done pulse when its wait expires; the sequencer FSMs stall on these pulses.

Parameters:
WbDataWidth, 16, width of each channel's wait value.
NumChannels, 4, number of independent timer channels (1..16).
PrescaleWidth, 8, width of the prescale value; tick period is prescale_i+1 clock cycles.

Ports:
clk_i  in  1  single clock; all logic on its rising edge.
rst_i  in  1  synchronous reset, active-high.
wait_start_i  in  NumChannels  per-channel start request, level-sampled.
wait_value_i  in  NumChannels*WbDataWidth  per-channel wait value, flat; channel c at bits [c*WbDataWidth +: WbDataWidth].
prescale_i  in  PrescaleWidth  prescale value, shared by all channels, latched per channel at start.
periodic_i  in  NumChannels  per-channel mode select, latched at start: 0 = one-shot, 1 = periodic.
abort_i  in  NumChannels  per-channel abort.
wait_done_o  out  NumChannels  per-channel done pulse, one cycle wide, registered.
busy_o  out  NumChannels  per-channel busy flag, registered.

Behaviour:
Clocking and reset:
- One clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset (including mid-operation) forces every channel to IDLE and clears all counters.
- All outputs are 0 during reset and in the first cycle after it. A wait in progress is discarded with no done pulse.

Per-channel FSM:
- States: IDLE, WAIT, DONE. All outputs are Moore, decoded from registered state.
- IDLE -> WAIT when wait_start_i[c]=1. On that edge, latch V=wait_value_i slice, P=prescale_i, M=periodic_i[c]; load cnt=V and pre=0.
- WAIT: a tick occurs when pre==P; on a tick pre clears, otherwise pre increments.
  - On a tick with cnt==0 -> DONE.
  - On a tick with cnt!=0 -> cnt decrements.
- DONE (one cycle):
  - M=0 -> IDLE.
  - M=1 -> WAIT, reload cnt=V, pre=0. V and P are not re-sampled.
- abort_i[c]=1 in WAIT or DONE -> IDLE on the next edge; no done pulse follows. Abort in IDLE has no effect.
- Abort has priority over start and over the expiry transition.

Outputs:
- wait_done_o[c]=1 exactly while the channel is in DONE.
- busy_o[c]=1 in WAIT or DONE.

Timing and boundary conditions:
- Latency: start asserted in cycle 0 -> wait_done_o high in cycle (V+1)*(P+1)+1. For V=0, P=0 this is cycle 2.
- Periodic mode: done pulses repeat every (V+1)*(P+1)+1 cycles until abort.
- V = all-ones is legal. cnt is a down-counter and never wraps; there is no overflow path.
- Start while busy: ignored, including a start presented during DONE. A new start is accepted in IDLE, at the earliest one cycle after the DONE cycle.
- Changes to wait_value_i, prescale_i or periodic_i while busy have no effect.
- Channels are fully independent. Simultaneous starts and expiries on different channels do not interact.

Decomposition:
- Package wtmdl_pkg: typedef enum logic [1:0] wt_state_t {IDLE, WAIT, DONE}, plus default parameter constants.
- Sub-module wtmdl_chan: one channel containing the FSM, prescaler and down-counter.
- Top wtmdl_mc: a generate loop of NumChannels wtmdl_chan instances and bus slicing; no shared state.

Test Plan:
1. ch0 V=0, P=0, one-shot, start for 1 cycle at cycle 0 -> wait_done_o[0] high in cycle 2 only; busy_o[0] high in cycles 1-2.
2. ch1 V=5, P=2, one-shot -> single done pulse in cycle 19. Changing wait_value_i and prescale_i at cycle 3 does not alter it.
3. ch2 V=2, P=0, periodic -> pulses in cycles 4, 8, 12. abort_i[2] in cycle 13 -> no further pulses; busy_o[2] low from cycle 14.
4. ch0 V=10, P=0 started; abort_i at cycle 5 together with wait_start_i -> IDLE, no pulse, start ignored. A fresh start at cycle 8 -> pulse in cycle 20.
5. Start held high continuously on ch3, V=1, P=0 -> pulses in cycles 3, 7, 11; restarts only from IDLE. All four channels started in the same cycle with V=0,1,2,3 -> pulses in cycles 2, 3, 4, 5 respectively.
6. rst_i asserted at cycle 4 during ch1 V=100 -> all outputs 0 from cycle 5, no pulse afterward. V=16'hFFFF, P=0 -> pulse at cycle 65537.

Source files
------------

// File: rtl/wtmdl_pkg.sv
// Shared types and default constants for the multi-channel wait timer.
// Imported by the channel and the top-level wrapper.
package wtmdl_pkg;

    // Per-channel FSM state encoding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } wt_state_t;

    localparam int unsigned WT_DEF_DATA_W = 16;
    localparam int unsigned WT_DEF_NUM_CH = 4;
    localparam int unsigned WT_DEF_PRE_W  = 8;

endpackage

// File: rtl/wtmdl_chan.sv
// One wait-timer channel: FSM, prescaler and down-counter.
// Start/mode/value/prescale are latched in IDLE; abort wins over all else.
module wtmdl_chan
    import wtmdl_pkg::*;
#(
    parameter int unsigned DataW = WT_DEF_DATA_W,
    parameter int unsigned PreW  = WT_DEF_PRE_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             i_start,
    input  logic [DataW-1:0] i_value,
    input  logic [PreW-1:0]  i_prescale,
    input  logic             i_periodic,
    input  logic             i_abort,
    output logic             o_done,
    output logic             o_busy
);

    wt_state_t        r_state;
    wt_state_t        w_state_nxt;
    logic [DataW-1:0] r_cnt;
    logic [DataW-1:0] w_cnt_nxt;
    logic [PreW-1:0]  r_pre;
    logic [PreW-1:0]  w_pre_nxt;
    logic [DataW-1:0] r_val;
    logic [DataW-1:0] w_val_nxt;
    logic [PreW-1:0]  r_plim;
    logic [PreW-1:0]  w_plim_nxt;
    logic             r_mode;
    logic             w_mode_nxt;
    logic             r_done;
    logic             r_busy;
    logic             w_tick;

    assign w_tick = (r_pre == r_plim);

    // Next-state logic plus counter, prescaler and latch updates.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pre_nxt   = r_pre;
        w_val_nxt   = r_val;
        w_plim_nxt  = r_plim;
        w_mode_nxt  = r_mode;
        unique case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_state_nxt = WAIT;
                    w_val_nxt   = i_value;
                    w_plim_nxt  = i_prescale;
                    w_mode_nxt  = i_periodic;
                    w_cnt_nxt   = i_value;
                    w_pre_nxt   = '0;
                end
            end
            WAIT: begin
                if (i_abort) begin
                    w_state_nxt = IDLE;
                end else if (w_tick) begin
                    w_pre_nxt = '0;
                    if (r_cnt == '0) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end else begin
                    w_pre_nxt = r_pre + 1'b1;
                end
            end
            DONE: begin
                if (i_abort) begin
                    w_state_nxt = IDLE;
                end else if (r_mode) begin
                    // Periodic: reload from the values latched at start.
                    w_state_nxt = WAIT;
                    w_cnt_nxt   = r_val;
                    w_pre_nxt   = '0;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, datapath and registered Moore outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_pre   <= '0;
            r_val   <= '0;
            r_plim  <= '0;
            r_mode  <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pre   <= w_pre_nxt;
            r_val   <= w_val_nxt;
            r_plim  <= w_plim_nxt;
            r_mode  <= w_mode_nxt;
            r_done  <= (w_state_nxt == DONE);
            r_busy  <= (w_state_nxt != IDLE);
        end
    end

    assign o_done = r_done;
    assign o_busy = r_busy;

endmodule

// File: rtl/wtmdl_mc.sv
// Multi-channel wait timer: NumChannels independent wtmdl_chan instances.
// Only bus slicing here; channels share no state.
module wtmdl_mc
    import wtmdl_pkg::*;
#(
    parameter int unsigned WbDataWidth   = WT_DEF_DATA_W,
    parameter int unsigned NumChannels   = WT_DEF_NUM_CH,
    parameter int unsigned PrescaleWidth = WT_DEF_PRE_W
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [NumChannels-1:0]             wait_start_i,
    input  logic [NumChannels*WbDataWidth-1:0] wait_value_i,
    input  logic [PrescaleWidth-1:0]           prescale_i,
    input  logic [NumChannels-1:0]             periodic_i,
    input  logic [NumChannels-1:0]             abort_i,
    output logic [NumChannels-1:0]             wait_done_o,
    output logic [NumChannels-1:0]             busy_o
);

    for (genvar c = 0; c < NumChannels; c++) begin : g_ch
        wtmdl_chan #(
            .DataW (WbDataWidth),
            .PreW  (PrescaleWidth)
        ) u_chan (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .i_start    (wait_start_i[c]),
            .i_value    (wait_value_i[c*WbDataWidth +: WbDataWidth]),
            .i_prescale (prescale_i),
            .i_periodic (periodic_i[c]),
            .i_abort    (abort_i[c]),
            .o_done     (wait_done_o[c]),
            .o_busy     (busy_o[c])
        );
    end

endmodule
